// File: rtl/ddr_cas_responder_if.sv
// ddr_cas_responder_if
//   CAS command and DQ data bundle between the controller's CAS scheduler
//   (master) and the device-side responder (slave).
//   Command side : cmd_valid, cmd_type, cmd_col, CL/AL/CWL, BL, wr_data
//   Response side: rd_data, rd_valid, wr_sample, rw_done, autopre_pulse,
//                  err_overflow, err_collision
interface ddr_cas_responder_if #(
    parameter int COL_W = 6,
    parameter int DQ_W  = 8
);
    logic               cmd_valid;
    logic [2:0]         cmd_type;
    logic [COL_W-1:0]   cmd_col;
    logic [4:0]         CL;
    logic [4:0]         AL;
    logic [4:0]         CWL;
    logic [3:0]         BL;
    logic [2*DQ_W-1:0]  wr_data;
    logic [2*DQ_W-1:0]  rd_data;
    logic               rd_valid;
    logic               wr_sample;
    logic               rw_done;
    logic               autopre_pulse;
    logic               err_overflow;
    logic               err_collision;

    modport master (
        output cmd_valid, cmd_type, cmd_col, CL, AL, CWL, BL, wr_data,
        input  rd_data, rd_valid, wr_sample, rw_done, autopre_pulse,
               err_overflow, err_collision
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_col, CL, AL, CWL, BL, wr_data,
        output rd_data, rd_valid, wr_sample, rw_done, autopre_pulse,
               err_overflow, err_collision
    );
endinterface

// File: rtl/ddr_cas_responder.sv
// ddr_pkg: CAS command encodings shared by the responder and its users.
//
// ddr_cas_responder
//   Device-side DRAM data model for CAS commands. Accepted RD/RDA/WR/WRA
//   commands wait in an in-order queue until their data window opens
//   (AL+CL or AL+CWL cycles after accept), then a burst FSM walks the
//   burst-aligned column block, reading from or writing into a local store.
//   Ports:
//     CK_t     - clock, rising edge
//     reset_n  - synchronous active-low reset (store contents survive it)
//     bus      - ddr_cas_responder_if.slave: command, latencies, burst
//                length, write data in; read data, burst strobes, rw_done,
//                autopre_pulse and sticky error flags out
//   Optional feature: define DDR_RSP_AUTOPRE_EN to pulse autopre_pulse on the
//   last beat of RDA/WRA bursts; otherwise autopre_pulse is constant 0.
package ddr_pkg;
    localparam logic [2:0] RD_R  = 3'b001;
    localparam logic [2:0] RDA_R = 3'b010;
    localparam logic [2:0] WR_R  = 3'b011;
    localparam logic [2:0] WRA_R = 3'b100;
endpackage

module ddr_cas_responder #(
    parameter int COL_W  = 6,
    parameter int DQ_W   = 8,
    parameter int QDEPTH = 4
) (
    input  logic                CK_t,
    input  logic                reset_n,
    ddr_cas_responder_if.slave  bus
);
    import ddr_pkg::*;

    localparam int QA_W  = $clog2(QDEPTH);
    localparam int DEPTH = 1 << COL_W;

    typedef enum logic [1:0] {RSP_IDLE, RSP_READ, RSP_WRITE} rsp_state_t;

    typedef struct packed {
        logic             is_rd;
        logic             autopre;
        logic             len4;     // 1: BL8 (4 cycles), 0: BL4 (2 cycles)
        logic [COL_W-1:0] col;
        logic [15:0]      start;
    } cas_entry_t;

    // Column for a given beat: low bits wrap inside the burst-aligned block.
    function automatic logic [COL_W-1:0] burst_addr(input logic [COL_W-1:0] col,
                                                    input logic             len4,
                                                    input logic [1:0]       beat);
        logic [COL_W-1:0] a;
        a = col;
        if (len4) a[1:0] = col[1:0] + beat;
        else      a[0]   = col[0] ^ beat[0];
        return a;
    endfunction

    rsp_state_t        state;
    logic [15:0]       tick;
    logic [15:0]       last_end;
    cas_entry_t        queue [QDEPTH];
    logic [QA_W-1:0]   wr_ptr, rd_ptr;
    logic [QA_W:0]     count;
    logic [1:0]        beat;
    logic              cur_len4, cur_autopre;
    logic [COL_W-1:0]  cur_col, addr;
    logic              rd_valid_q, wr_sample_q, rw_done_q, autopre_q;
    logic              err_overflow_q, err_collision_q;
    logic [2*DQ_W-1:0] mem [DEPTH];

    // Command decode and window computation
    logic        cmd_rd, cmd_wr, cmd_ap, cmd_cas, cmd_len4;
    logic [5:0]  lat_sum, lat;
    logic [15:0] cmd_start, cmd_end, start_vs_end;
    cas_entry_t  new_entry;

    assign cmd_rd   = (bus.cmd_type == RD_R) || (bus.cmd_type == RDA_R);
    assign cmd_wr   = (bus.cmd_type == WR_R) || (bus.cmd_type == WRA_R);
    assign cmd_cas  = bus.cmd_valid && (cmd_rd || cmd_wr);
    assign cmd_len4 = (bus.BL != 4'd4);
`ifdef DDR_RSP_AUTOPRE_EN
    assign cmd_ap   = (bus.cmd_type == RDA_R) || (bus.cmd_type == WRA_R);
`else
    assign cmd_ap   = 1'b0;
`endif
    assign lat_sum   = {1'b0, bus.AL} + (cmd_rd ? {1'b0, bus.CL} : {1'b0, bus.CWL});
    assign lat       = (lat_sum == 6'd0) ? 6'd1 : lat_sum;
    assign cmd_start = tick + {10'd0, lat};
    assign cmd_end   = cmd_start + (cmd_len4 ? 16'd3 : 16'd1);
    assign new_entry = '{is_rd: cmd_rd, autopre: cmd_ap, len4: cmd_len4,
                         col: bus.cmd_col, start: cmd_start};

    // Queue head timing. tick here is the pre-edge count, so a head whose
    // start equals tick opens its burst on this edge; the same compare
    // serves both the idle start and a back-to-back chain off a last beat.
    cas_entry_t  head;
    logic [15:0] tick_vs_head;
    logic        head_vld, head_due, head_late;
    logic        active, burst_last, issue, pop, busy, q_full, collide, push;
    logic [1:0]  last_beat, next_beat;

    assign head         = queue[rd_ptr];
    assign head_vld     = (count != '0);
    assign tick_vs_head = tick - head.start;
    assign head_due     = head_vld && (tick_vs_head == 16'd0);
    assign head_late    = head_vld && !tick_vs_head[15] && (tick_vs_head != 16'd0);
    assign active       = (state != RSP_IDLE);
    assign last_beat    = cur_len4 ? 2'd3 : 2'd1;
    assign next_beat    = beat + 2'd1;
    assign burst_last   = active && (beat == last_beat);
    assign issue        = head_due && (!active || burst_last);
    assign pop          = issue || head_late;
    // last_end is only meaningful while something is queued or bursting.
    assign busy         = head_vld || active;
    assign q_full       = (count == (QA_W+1)'(QDEPTH)) && !pop;
    assign start_vs_end = cmd_start - last_end;
    assign collide      = busy && (start_vs_end[15] || (start_vs_end == 16'd0));
    assign push         = cmd_cas && !q_full && !collide;

    always_ff @(posedge CK_t) begin
        if (push) queue[wr_ptr] <= new_entry;
    end

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            state           <= RSP_IDLE;
            tick            <= '0;
            last_end        <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            beat            <= '0;
            cur_len4        <= 1'b0;
            cur_autopre     <= 1'b0;
            cur_col         <= '0;
            addr            <= '0;
            rd_valid_q      <= 1'b0;
            wr_sample_q     <= 1'b0;
            rw_done_q       <= 1'b0;
            autopre_q       <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_collision_q <= 1'b0;
        end else begin
            tick <= tick + 16'd1;

            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                last_end <= cmd_end;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (cmd_cas && q_full)       err_overflow_q  <= 1'b1;
            else if (cmd_cas && collide) err_collision_q <= 1'b1;
            // A head that missed its slot is discarded and flagged.
            if (head_late)               err_collision_q <= 1'b1;

            rw_done_q <= 1'b0;
            autopre_q <= 1'b0;
            if (issue) begin
                state       <= head.is_rd ? RSP_READ : RSP_WRITE;
                beat        <= 2'd0;
                cur_col     <= head.col;
                cur_len4    <= head.len4;
                cur_autopre <= head.autopre;
                addr        <= head.col;
                rd_valid_q  <= head.is_rd;
                wr_sample_q <= !head.is_rd;
            end else if (active && !burst_last) begin
                beat      <= next_beat;
                addr      <= burst_addr(cur_col, cur_len4, next_beat);
                rw_done_q <= (next_beat == last_beat);
                autopre_q <= (next_beat == last_beat) && cur_autopre;
            end else begin
                state       <= RSP_IDLE;
                rd_valid_q  <= 1'b0;
                wr_sample_q <= 1'b0;
            end
        end
    end

    // Store is not reset; a write cycle cut short by reset is not committed.
    always_ff @(posedge CK_t) begin
        if (reset_n && wr_sample_q) mem[addr] <= bus.wr_data;
    end

    assign bus.rd_data       = rd_valid_q ? mem[addr] : '0;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.wr_sample     = wr_sample_q;
    assign bus.rw_done       = rw_done_q;
    assign bus.autopre_pulse = autopre_q;
    assign bus.err_overflow  = err_overflow_q;
    assign bus.err_collision = err_collision_q;
endmodule

// File: doc/ddr_cas_responder.md
# ddr_cas_responder

Device-side responder for CAS commands issued by the controller's burst/CAS scheduler. Accepts RD/RDA/WR/WRA commands with a column address, holds them in an in-order pending queue, and opens each data burst after the programmed read or write latency. Read data is driven from a small column store, write data is captured into it, and a one-cycle `rw_done` marks the last beat of every burst. Sits between the CAS command path and the DQ datapath and acts as the bench-side DRAM data model.

## Interface
Parameters:
- `COL_W`, 6: column address width; store depth is 2^COL_W words.
- `DQ_W`, 8: DQ width; one clock carries two beats, so data ports are 2*DQ_W.
- `QDEPTH`, 4: pending command queue depth (power of 2).

Ports:
- `CK_t`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  one-cycle CAS command strobe; no backpressure.
- `cmd_type`  in  3  `RD_R`/`RDA_R`/`WR_R`/`WRA_R` encodings from `ddr_pkg`.
- `cmd_col`  in  COL_W  starting column.
- `CL`, `AL`, `CWL`  in  5 each  programmed latencies, sampled at command accept.
- `BL`  in  4  burst length, 8 or 4; sampled at accept.
- `wr_data`  in  2*DQ_W  write data, sampled on write burst cycles.
- `rd_data`  out  2*DQ_W  read data, valid when `rd_valid`.
- `rd_valid`  out  1  read burst cycle.
- `wr_sample`  out  1  write burst cycle (`wr_data` captured).
- `rw_done`  out  1  pulse in the last cycle of any burst.
- `autopre_pulse`  out  1  see Configuration.
- `err_overflow`  out  1  sticky: command arrived with queue full.
- `err_collision`  out  1  sticky: command's data window overlaps a queued/active burst.

## Operation
- Free-running 16-bit `tick` counter; all time compares use modular (wrap-safe) difference.
- On `cmd_valid`: lat = AL+CL (read) or AL+CWL (write), 6-bit, clamped to min 1; start = tick+lat; len = BL/2 cycles; end = start+len-1.
- Accept checks, in priority order: queue full -> drop, set `err_overflow`; start <= `last_end` (end of youngest queued or active burst) -> drop, set `err_collision`; else push {type, col, start, len} and update `last_end`.
- Burst FSM states: `RSP_IDLE`, `RSP_READ`, `RSP_WRITE`.
  - `RSP_IDLE`: if queue non-empty and head.start == tick -> pop, load beat counter = 0, go `RSP_READ`/`RSP_WRITE` by type.
  - `RSP_READ`/`RSP_WRITE`: each cycle beat++; on beat == len-1 pulse `rw_done`; then if next head.start == tick+1 chain directly (back-to-back, no idle cycle), else `RSP_IDLE`.
- Address per cycle: {col[COL_W-1:log2(len)], (col[low bits] + beat) mod len} — wraps within aligned burst block.
- Read: `rd_data` = store[addr], combinational from registered addr; write: store[addr] <= `wr_data` on each write cycle.
- Reset mid-burst: FSM to idle, queue flushed, store contents retained, sticky errors cleared.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `wr_sample`=0, `rw_done`=0, `autopre_pulse`=0, `err_*`=0, tick=0, queue empty.
- Command accepted at edge T -> first burst cycle is cycle T+lat (registered outputs high that cycle); last at T+lat+len-1.
- `rw_done` coincident with last `rd_valid`/`wr_sample` cycle, exactly one cycle.
- Command in the same cycle a burst ends: accepted normally if start > `last_end`.
- Pop and push in same cycle when queue full: push succeeds (pop frees slot first).
- Head whose start has passed without being issued cannot occur by construction; if detected, entry dropped and `err_collision` set.

## Configuration
- `DDR_RSP_AUTOPRE_EN` defined: RDA_R/WRA_R bursts pulse `autopre_pulse` one cycle, coincident with their `rw_done`; RD_R/WR_R never do.
- Not defined: `autopre_pulse` tied 0; RDA_R/WRA_R handled identically to RD_R/WR_R.

## Test plan
- WR_R col 0x10, AL=0 CWL=5 BL=8, data 0x0101..0x0404 -> `wr_sample` cycles T+5..T+8, `rw_done` at T+8; later RD_R col 0x10, CL=11 -> `rd_valid` T+11..T+14 returning 0x0101..0x0404.
- RD_R col 0x06 BL=8 -> read order cols 6,7,4,5 (wrap in block of 4).
- Two RD_R 4 cycles apart, CL=11 -> bursts back-to-back, no idle gap, two `rw_done` pulses 4 cycles apart.
- RD_R then WR_R 1 cycle later, CL=11 CWL=5 -> second dropped, `err_collision`=1, first burst unaffected.
- Five commands spaced 4 cycles with CL=20, QDEPTH=4 -> fifth dropped, `err_overflow`=1; reset_n low 1 cycle mid-burst -> all outputs 0 next cycle, errors cleared.
- With `DDR_RSP_AUTOPRE_EN`: RDA_R -> `autopre_pulse` with `rw_done`; without macro -> stays 0.
